// File: rtl/bsram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bsram_port_arbiter
// Purpose  : Round-robin, burst-bounded sharing of one block-SRAM port between
//            N requesters, with tagged read-data return.
// Revision : 1.0
// ============================================================================
module bsram_port_arbiter #(
    parameter int N         = 3,
    parameter int A_SIZE    = 10,
    parameter int W_SIZE    = 16,
    parameter int MAX_BURST = 4,
    parameter int RD_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic [N-1:0]          we,
    input  logic [N*A_SIZE-1:0]   addr,
    input  logic [N*W_SIZE-1:0]   wdata,
    output logic [N-1:0]          gnt,
    output logic [N-1:0]          rvalid,
    output logic [W_SIZE-1:0]     rdata,
    output logic                  mem_ce,
    output logic                  mem_wre,
    output logic [A_SIZE-1:0]     mem_ad,
    output logic [W_SIZE-1:0]     mem_din,
    input  logic [W_SIZE-1:0]     mem_dout
);

    localparam int         PW          = (N > 1) ? $clog2(N) : 1;
    localparam logic [7:0] C_MAX_BURST = 8'(MAX_BURST);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_OWN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [PW-1:0]   w_win;
    logic            w_grant;
    logic [N-1:0]    w_others;
    logic [N-1:0]    tag_q [RD_LAT];

    // First asserted request scanning p+1, p+2, ... modulo N.
    function automatic logic [PW-1:0] f_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
        int idx;
        f_pick = p;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(p) + k) % N;
            if (r[idx]) f_pick = PW'(idx);
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        w_win    = owner_q;
        w_grant  = 1'b0;
        w_others = req & ~(N'(1) << owner_q);
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    w_win   = f_pick(req, ptr_q);
                    w_grant = 1'b1;
                    state_d = S_OWN;
                    owner_d = w_win;
                    cnt_d   = 8'd1;
                end
            end
            S_OWN: begin
                if (req[owner_q] && (cnt_q < C_MAX_BURST)) begin
                    w_grant = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end else if (req[owner_q] && (w_others == '0)) begin
                    w_grant = 1'b1;
                    cnt_d   = 8'd1;
                end else if (|w_others) begin
                    // Scanning from the old owner leaves it with lowest priority.
                    ptr_d   = owner_q;
                    w_win   = f_pick(req, owner_q);
                    w_grant = 1'b1;
                    owner_d = w_win;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = S_IDLE;
                    ptr_d   = owner_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (reset) w_grant = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= PW'(N - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt     = w_grant ? (N'(1) << w_win) : '0;
    assign mem_ce  = w_grant;
    assign mem_wre = w_grant & we[w_win];
    assign mem_ad  = w_grant ? addr[w_win*A_SIZE +: A_SIZE]  : '0;
    assign mem_din = w_grant ? wdata[w_win*W_SIZE +: W_SIZE] : '0;

    // Read tags ride alongside the SRAM latency so data returns to its issuer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < RD_LAT; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0] <= gnt & ~we;
            for (int k = 1; k < RD_LAT; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    assign rvalid = reset ? '0 : tag_q[RD_LAT-1];
    assign rdata  = mem_dout;

endmodule
`default_nettype wire

// File: tb/tb_bsram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsram_port_arbiter
// Purpose  : Directed and randomized bench for bsram_port_arbiter against a
//            rule-level arbitration model and a reference memory.
// Revision : 1.0
// ============================================================================
module tb_bsram_port_arbiter;

    localparam int N = 3, A = 10, W = 16, MAXB = 4, LAT = 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, we, gnt, rvalid;
    logic [N*A-1:0] addr;
    logic [N*W-1:0] wdata;
    logic [W-1:0]   rdata, mem_din, mem_dout;
    logic [A-1:0]   mem_ad;
    logic           mem_ce, mem_wre;

    bsram_port_arbiter #(.N(N), .A_SIZE(A), .W_SIZE(W), .MAX_BURST(MAXB), .RD_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_ce(mem_ce), .mem_wre(mem_wre),
        .mem_ad(mem_ad), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM port: one-cycle registered read, write-then-read coherent.
    logic [W-1:0] sram [1024];
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_wre) sram[mem_ad] <= mem_din;
            else         mem_dout     <= sram[mem_ad];
        end
    end

    int n_vec = 0, n_err = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: who owns the port, how long the current burst is,
    // who was served last, the memory contents and the reads still in flight.
    typedef struct { int due; int idx; logic [W-1:0] data; } rd_t;
    rd_t          rq[$];
    logic [W-1:0] ref_mem [1024];
    int           m_owner = -1, m_run = 0, m_last = N - 1;
    logic [N-1:0] last_gnt = '0;

    function automatic int rr(input logic [N-1:0] r, input int from);
        for (int k = 1; k <= N; k++) if (r[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    always @(negedge clk) begin
        int           ew;
        logic [N-1:0] eg, erv;
        logic [W-1:0] erd;
        logic         mine, rest;
        cyc++;
        ew  = -1;
        erv = '0;
        erd = '0;
        if (reset) begin
            rq.delete();
            m_owner = -1; m_run = 0; m_last = N - 1;
        end else begin
            if (rq.size() > 0 && rq[0].due == cyc) begin
                erv = N'(1) << rq[0].idx;
                erd = rq[0].data;
                void'(rq.pop_front());
            end
            if (m_owner < 0) begin
                if (req != '0) begin
                    ew = rr(req, m_last); m_owner = ew; m_run = 1;
                end
            end else begin
                mine = req[m_owner];
                rest = (req & ~(N'(1) << m_owner)) != '0;
                if (mine && m_run < MAXB) begin
                    ew = m_owner; m_run++;
                end else if (mine && !rest) begin
                    ew = m_owner; m_run = 1;
                end else if (rest) begin
                    m_last = m_owner; ew = rr(req, m_owner); m_owner = ew; m_run = 1;
                end else begin
                    m_last = m_owner; m_owner = -1; m_run = 0;
                end
            end
        end
        eg = (ew >= 0) ? (N'(1) << ew) : '0;
        chk("gnt",    32'(gnt),     32'(eg));
        chk("ce",     32'(mem_ce),  32'(ew >= 0));
        chk("wre",    32'(mem_wre), 32'((ew >= 0) && we[ew]));
        chk("ad",     32'(mem_ad),  (ew >= 0) ? 32'(addr[ew*A +: A])  : 32'd0);
        chk("din",    32'(mem_din), (ew >= 0) ? 32'(wdata[ew*W +: W]) : 32'd0);
        chk("rvalid", 32'(rvalid),  32'(erv));
        if (erv != '0) chk("rdata", 32'(rdata), 32'(erd));
        if (ew >= 0) begin
            if (we[ew]) ref_mem[addr[ew*A +: A]] = wdata[ew*W +: W];
            else rq.push_back('{due: cyc + LAT, idx: ew, data: ref_mem[addr[ew*A +: A]]});
        end
        last_gnt = eg;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_rq(input int i, input logic w, input logic [A-1:0] a, input logic [W-1:0] d);
        req[i] = 1'b1; we[i] = w; addr[i*A +: A] = a; wdata[i*W +: W] = d;
    endtask

    task automatic new_rq(input int i);
        logic [A-1:0] a;
        a = ($urandom_range(3) == 0) ? A'($urandom_range(1023)) : A'($urandom_range(15));
        set_rq(i, 1'($urandom_range(1)), a, W'($urandom));
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) begin sram[k] = '0; ref_mem[k] = '0; end
        reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        step(); step();
        reset = 1'b0;
        // Write 0xBEEF, then read it back through requester 0.
        set_rq(0, 1'b1, 10'h005, 16'hBEEF); step();
        set_rq(0, 1'b0, 10'h005, 16'h0000); step();
        req = '0; step(); step();
        // All three requesting from reset: burst of 4 to r0, then r1.
        reset = 1'b1; step(); reset = 1'b0;
        set_rq(0, 1'b0, 10'h001, '0); set_rq(1, 1'b0, 10'h002, '0); set_rq(2, 1'b0, 10'h003, '0);
        repeat (6) step();
        req = '0; step(); step();
        // r2 streams writes across the address wrap.
        for (int k = 0; k < 10; k++) begin
            set_rq(2, 1'b1, A'((10'h3F8 + k) & 10'h3FF), W'(16'h1000 + k)); step();
        end
        req = '0; step();
        // Interleaved reads from r0, r1, r0.
        req = '0; set_rq(0, 1'b0, 10'h3F8, '0); step();
        req = '0; set_rq(1, 1'b0, 10'h3F9, '0); step();
        req = '0; set_rq(0, 1'b0, 10'h3FA, '0); step();
        req = '0; step(); step();
        // Reset right after a read grant drops the read.
        set_rq(0, 1'b0, 10'h3FB, '0); step();
        req = '0; reset = 1'b1; set_rq(1, 1'b0, 10'h004, '0); set_rq(2, 1'b0, 10'h005, '0); step();
        reset = 1'b0; repeat (3) step();
        req = '0; step();
        // Randomized traffic with varying request density and burst appetite.
        for (int ph = 0; ph < 6; ph++) begin
            int rate, keep;
            rate = 10 + ph * 15;
            keep = (ph % 2 == 0) ? 85 : 30;
            for (int c = 0; c < 500; c++) begin
                reset = ($urandom_range(199) == 0);
                for (int i = 0; i < N; i++) begin
                    if (req[i] && last_gnt[i]) begin
                        if ($urandom_range(99) < keep) new_rq(i); else req[i] = 1'b0;
                    end else if (req[i]) begin
                        if ($urandom_range(99) < 3) req[i] = 1'b0;
                    end else if ($urandom_range(99) < rate) begin
                        new_rq(i);
                    end
                end
                step();
            end
        end
        reset = 1'b0; req = '0;
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bsram_port_arbiter.md
Name: bsram_port_arbiter

Overview:
- Shares one port of the 16-bit x 1024 dual-port block SRAM between N requesters, for example CPU fetch, CPU data and DMA.
- Uses round-robin arbitration with bounded bursts, so a streaming requester keeps the port for consecutive cycles but cannot starve the others.
- Routes registered read data back to the requester that issued the read, with a per-requester valid strobe.
- Sits between the requester masters and the SRAM port's ce/wre/ad/din/dout pins.

Parameters:
- N, 3, number of requesters (2..8).
- A_SIZE, 10, SRAM address width.
- W_SIZE, 16, SRAM data width.
- MAX_BURST, 4, maximum consecutive grants to one owner while another requester is waiting (1..255).
- RD_LAT, 1, SRAM read latency in cycles, from ce/address to valid dout (1..3).

Ports:
- clk  in  1  Single clock, shared with the SRAM port.
- reset  in  1  Synchronous, active-high.
- req  in  N  Per-requester access request, held until granted.
- we  in  N  Per-requester write enable, qualifies req.
- addr  in  N*A_SIZE  Packed addresses; requester i uses bits [i*A_SIZE +: A_SIZE].
- wdata  in  N*W_SIZE  Packed write data, same packing as addr.
- gnt  out  N  One-hot grant. The transfer happens in any cycle where req[i] and gnt[i] are both 1.
- rvalid  out  N  One-hot read-data valid.
- rdata  out  W_SIZE  Read data, shared by all requesters and qualified by rvalid.
- mem_ce  out  1  SRAM clock enable.
- mem_wre  out  1  SRAM write enable.
- mem_ad  out  A_SIZE  SRAM address.
- mem_din  out  W_SIZE  SRAM write data.
- mem_dout  in  W_SIZE  SRAM read data.

Behaviour:
- Reset is synchronous, active-high and fixed, on the single clock clk.
- Values while reset=1:
  - gnt=0, rvalid=0, mem_ce=0, mem_wre=0.
  - State=IDLE, cnt=0.
  - Round-robin pointer ptr=N-1, so requester 0 has highest priority first.
  - The read-tag pipeline is cleared, so in-flight reads are dropped and produce no rvalid.
- Grant path:
  - gnt is combinational from req and the registered state, so there is zero-cycle grant latency.
  - mem_ce = |gnt. mem_wre = we[w] & gnt[w]. mem_ad and mem_din are muxed from winner w.
  - When no grant is issued, mem_ad and mem_din are 0.
- Winner selection: the first asserted req scanning ptr+1, ptr+2, ... modulo N.
- FSM state IDLE:
  - No req: stay in IDLE.
  - Any req: grant winner w, go to OWN, owner=w, cnt=1.
- FSM state OWN (registers owner and cnt):
  - req[owner]=1 and cnt<MAX_BURST: regrant owner, cnt=cnt+1.
  - req[owner]=1, cnt==MAX_BURST, no other req: regrant owner with no bubble, cnt=1.
  - Otherwise, if another req is pending: ptr=owner, grant the new winner (the owner now has lowest priority), owner=w, cnt=1.
  - req[owner]=0 and no other req: go to IDLE, ptr=owner, no grant this cycle.
- Handshake rules:
  - A requester must hold req, we, addr and wdata stable until it is granted.
  - Dropping req before grant is legal and withdraws the request.
- Read return:
  - Each granted read (we=0) pushes its one-hot tag into an RD_LAT-deep shift register.
  - rvalid = tag at the tail, rdata = mem_dout.
  - Exactly one rvalid pulse per granted read, RD_LAT cycles after its grant cycle.
  - Reads back-to-back at one per cycle return at one per cycle.
  - Writes produce no rvalid.
- Write/read ordering: a read granted in the cycle after a write to the same address returns the new data. The SRAM port guarantees this, and the arbiter inserts no forwarding.
- At most one bit of gnt and one bit of rvalid is set in any cycle.
- cnt is 8 bits wide and never exceeds MAX_BURST.

Test Plan:
All scenarios use N=3, MAX_BURST=4, RD_LAT=1.
1. Reset, then req=001 read addr 0x005 after a prior write of 0xBEEF -> gnt=001 in the same cycle, mem_ce=1, mem_ad=0x005, next cycle rvalid=001 and rdata=0xBEEF.
2. req=111 held for 6 cycles from reset -> gnt sequence 001,001,001,001,010,010, and mem_ce=1 in every cycle.
3. Round-robin check: after requester 1 completes a burst, req=101 -> gnt=100 first, then 001.
4. Requester 2 alone streams 10 writes, addresses 0x3F8..0x3FF then 0x000..0x001 -> gnt=100 on all 10 cycles with no gap, and mem_ad wraps 0x3FF->0x000 as supplied.
5. Reads interleaved: r0 read A, r1 read B, r0 read C on consecutive cycles -> rvalid 001,010,001 on the following three cycles, carrying the data of A, B and C.
6. reset=1 asserted in the cycle after a read grant -> no rvalid, gnt=0, mem_ce=0. After reset releases, req=110 -> gnt=010 first.
